sdbm_hash_engine: RTL and testbench
===================================

# sdbm_hash_engine

Parametrised, multi-byte-per-cycle sdbm string hash engine for the DNS query path. It accepts a packed query name of up to MAX_BYTES bytes with an explicit length and hashes LANES bytes per clock. It returns a HASH_WIDTH-bit digest and the number of bytes hashed over a valid/ready stream. It sits between the qname extractor and the cache lookup, and supersedes the fixed 2048-bit single-lane hasher.

## Interface
- MAX_BYTES, 256: capacity of s_data in bytes (≥1).
- LANES, 1: bytes hashed per clock (1, 2, 4 or 8).
- HASH_WIDTH, 32: digest width (≥17).
- LW (derived, not overridable): $clog2(MAX_BYTES+1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  MAX_BYTES*8  packed name; byte i = s_data[(MAX_BYTES-1-i)*8 +: 8], so byte 0 sits at the MSBs.
- s_len  in  LW  number of valid bytes; values above MAX_BYTES are clamped to MAX_BYTES.
- s_valid  in  1  input request.
- s_ready  out  1  input accept.
- m_hash  out  HASH_WIDTH  digest.
- m_len  out  LW  bytes actually hashed.
- m_valid  out  1  result valid.
- m_ready  in  1  result accept.

## Operation
- Hash recurrence per byte c, starting from h=0: h = c + (h<<6) + (h<<16) − h, computed modulo 2^HASH_WIDTH; c is zero-extended.
- Bytes are hashed in order 0..len−1. Every byte is included: there is no skipped byte.
- State machine states:
  - IDLE: s_ready=1 when m_valid=0. On s_valid&&s_ready, the block registers s_data and clamp(s_len), clears h and the byte index, and goes to HASH.
  - HASH: each cycle applies up to LANES chained steps. Lanes at or beyond the remaining length are bypassed, leaving h unchanged. When index+LANES ≥ len (or len=0), the block loads m_hash/m_len, sets m_valid, and goes to DONE.
  - DONE: m_hash/m_len are held stable while m_valid=1. On m_ready, m_valid clears and the block goes to IDLE.
- s_data and s_len may change after acceptance without effect.
- len=0 → m_hash=0, m_len=0.

## Timing
- Reset values: s_ready=0, m_valid=0, m_hash=0, m_len=0, state=IDLE. s_ready first rises on the cycle after reset deasserts.
- A reset asserted mid-operation aborts the job immediately; no partial result is ever presented.
- All outputs are registered.
- Latency: accept on edge E; m_valid rises on edge E+N, where N = max(1, ceil(len/LANES)).
- s_ready is 0 from edge E until the edge after the m_valid&&m_ready handshake. There is no overlap between jobs, so throughput is one name per N+2 cycles.
- If m_ready is held high, m_valid is high for exactly one cycle.
- m_ready while m_valid=0 is ignored.
- s_valid while s_ready=0 is ignored; the source must hold s_valid until accepted.

## Configuration
- SDBM_NUL_STOP_EN defined: hashing terminates at the first 0x00 byte within len. That byte and everything after it are excluded, and m_len is the index of the NUL. Termination is detected within the current cycle's lanes, so N shrinks accordingly.
- SDBM_NUL_STOP_EN undefined: 0x00 bytes are hashed like any other byte, and m_len always equals the clamped len.

## Structure
- Package sdbm_pkg holds:
  - the state encoding constants (IDLE/HASH/DONE);
  - the SDBM_SHIFT_A=6 and SDBM_SHIFT_B=16 constants;
  - the length-clamp helper.
- Sub-module sdbm_step: purely combinational, one byte update (h_in, c, en → h_out), instantiated LANES times in a chain.
- The top level holds the FSM, the capture register, the byte index and the output registers.

## Test plan
- LANES=1, "a" (0x61), len=1 → m_hash=0x00000061, m_len=1, m_valid on edge E+1.
- LANES=1, "ab", len=2 → m_hash=0x00611841, m_len=2, m_valid on edge E+2. Repeat with LANES=4 → same hash, m_valid on E+1.
- len=0 → m_hash=0, m_len=0, m_valid on E+1. s_len=MAX_BYTES+5 → m_len=MAX_BYTES, and the hash matches the model over all bytes.
- "a",0x00,"b", len=3 → without the macro, m_hash=0x2FC3E043 and m_len=3; with SDBM_NUL_STOP_EN, m_hash=0x00000061 and m_len=1.
- Hold m_ready=0 for 10 cycles after m_valid → m_hash stable and s_ready=0 throughout. Raise m_ready → m_valid drops next edge, and s_ready rises on the same edge.
- Assert rst during HASH → next cycle all outputs are 0 and no m_valid follows. A subsequent "ab" still yields 0x00611841.

Source files
------------

// File: rtl/sdbm_pkg.sv
// Shared constants, state encoding and length clamp for the sdbm hash engine.
package sdbm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHash = 2'd1,
        StDone = 2'd2
    } sdbm_state_e;

    localparam int unsigned SDBM_SHIFT_A = 6;
    localparam int unsigned SDBM_SHIFT_B = 16;

    function automatic int unsigned sdbm_clamp_len(input int unsigned len,
                                                   input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sdbm_step.sv
// One sdbm byte update: h' = c + (h << 6) + (h << 16) - h, or pass-through when disabled.
module sdbm_step
    import sdbm_pkg::*;
#(
    parameter int unsigned HASH_WIDTH = 32
) (
    input  logic [HASH_WIDTH-1:0] h_i,
    input  logic [7:0]            c_i,
    input  logic                  en_i,
    output logic [HASH_WIDTH-1:0] h_o
);

    logic [HASH_WIDTH-1:0] c_ext;
    logic [HASH_WIDTH-1:0] h_next;

    always_comb begin
        c_ext  = {{(HASH_WIDTH - 8){1'b0}}, c_i};
        h_next = c_ext + (h_i << SDBM_SHIFT_A) + (h_i << SDBM_SHIFT_B) - h_i;
        h_o    = en_i ? h_next : h_i;
    end

endmodule

// File: rtl/sdbm_hash_engine.sv
// Multi-lane sdbm hasher over a packed name with explicit length, valid/ready on both sides.
// Optional build macro SDBM_NUL_STOP_EN stops hashing at the first 0x00 byte within len.
module sdbm_hash_engine
    import sdbm_pkg::*;
#(
    parameter int unsigned MAX_BYTES  = 256,
    parameter int unsigned LANES      = 1,
    parameter int unsigned HASH_WIDTH = 32,
    localparam int         LW         = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_BYTES*8-1:0] s_data_i,
    input  logic [LW-1:0]          s_len_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [HASH_WIDTH-1:0]  m_hash_o,
    output logic [LW-1:0]          m_len_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);

    sdbm_state_e             state_q;
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic [HASH_WIDTH-1:0]   m_hash_q;
    logic [LW-1:0]           m_len_q;
    logic [HASH_WIDTH-1:0]   h_q;
    logic [LW-1:0]           idx_q;
    logic [LW-1:0]           len_q;
    logic [MAX_BYTES*8-1:0]  data_q;

    logic [7:0]              lane_byte [LANES];
    logic [HASH_WIDTH-1:0]   chain     [LANES+1];
    logic [LANES-1:0]        in_range;
    logic [LANES-1:0]        lane_en;
    logic                    range_done;
    logic                    done;

    assign chain[0]   = h_q;
    assign range_done = (32'(idx_q) + LANES) >= 32'(len_q);

`ifdef SDBM_NUL_STOP_EN
    logic [LANES:0] nul_seen;
    assign nul_seen[0] = 1'b0;
    assign done        = range_done | nul_seen[LANES];
`else
    assign done        = range_done;
`endif

    // data_q is shifted left as bytes are consumed, so lane l always reads byte idx_q + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        if (l < MAX_BYTES) begin : g_byte
            assign lane_byte[l] = data_q[(MAX_BYTES-1-l)*8 +: 8];
        end else begin : g_pad
            assign lane_byte[l] = 8'h00;
        end

        assign in_range[l] = (32'(idx_q) + l) < 32'(len_q);

`ifdef SDBM_NUL_STOP_EN
        assign nul_seen[l+1] = nul_seen[l] | (in_range[l] & (lane_byte[l] == 8'h00));
        assign lane_en[l]    = in_range[l] & ~nul_seen[l+1];
`else
        assign lane_en[l]    = in_range[l];
`endif

        sdbm_step #(
            .HASH_WIDTH(HASH_WIDTH)
        ) u_step (
            .h_i (chain[l]),
            .c_i (lane_byte[l]),
            .en_i(lane_en[l]),
            .h_o (chain[l+1])
        );
    end

    // Enabled lanes are always a contiguous prefix, so their count extends the hashed length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_hash_q  <= '0;
            m_len_q   <= '0;
            h_q       <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            data_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s_valid_i && s_ready_q) begin
                        s_ready_q <= 1'b0;
                        data_q    <= s_data_i;
                        len_q     <= LW'(sdbm_clamp_len(32'(s_len_i), MAX_BYTES));
                        h_q       <= '0;
                        idx_q     <= '0;
                        state_q   <= StHash;
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                StHash: begin
                    if (done) begin
                        m_hash_q  <= chain[LANES];
                        m_len_q   <= idx_q + LW'($countones(lane_en));
                        m_valid_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        h_q    <= chain[LANES];
                        idx_q  <= idx_q + LW'(LANES);
                        data_q <= data_q << (LANES * 8);
                    end
                end
                StDone: begin
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_hash_o  = m_hash_q;
    assign m_len_o   = m_len_q;

endmodule

// File: tb/tb_sdbm_hash_engine.sv
// Directed bench: a 1-lane and a 4-lane engine (MAX_BYTES=8) driven with identical jobs.
module tb_sdbm_hash_engine;

    localparam int unsigned MB = 8;
    localparam int          LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   s_data;
    logic [LW-1:0] s_len;
    logic          s_valid;
    logic          m_ready;

    logic          s_ready_1, s_ready_4, m_valid_1, m_valid_4;
    logic [31:0]   m_hash_1, m_hash_4;
    logic [LW-1:0] m_len_1, m_len_4;
    logic [1:0]    s_ready, m_valid;
    logic [31:0]   m_hash [2];
    logic [LW-1:0] m_len  [2];

    int n_cmp = 0;
    int n_err = 0;

    assign s_ready   = {s_ready_4, s_ready_1};
    assign m_valid   = {m_valid_4, m_valid_1};
    assign m_hash[0] = m_hash_1;
    assign m_hash[1] = m_hash_4;
    assign m_len[0]  = m_len_1;
    assign m_len[1]  = m_len_4;

    always #5 clk = ~clk;

    sdbm_hash_engine #(.MAX_BYTES(MB), .LANES(1), .HASH_WIDTH(32)) u_dut_1 (
        .clk(clk), .rst(rst), .s_data_i(s_data), .s_len_i(s_len), .s_valid_i(s_valid),
        .s_ready_o(s_ready_1), .m_hash_o(m_hash_1), .m_len_o(m_len_1),
        .m_valid_o(m_valid_1), .m_ready_i(m_ready)
    );

    sdbm_hash_engine #(.MAX_BYTES(MB), .LANES(4), .HASH_WIDTH(32)) u_dut_4 (
        .clk(clk), .rst(rst), .s_data_i(s_data), .s_len_i(s_len), .s_valid_i(s_valid),
        .s_ready_o(s_ready_4), .m_hash_o(m_hash_4), .m_len_o(m_len_4),
        .m_valid_o(m_valid_4), .m_ready_i(m_ready)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sdbm_ref(input logic [63:0] d, input int n);
        logic [31:0] h;
        logic [7:0]  c;
        h = '0;
        for (int i = 0; i < n; i++) begin
            c = d[(7-i)*8 +: 8];
            h = {24'h0, c} + (h << 6) + (h << 16) - h;
        end
        return h;
    endfunction

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (s_ready != 2'b11 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("%s/ready", tag), 64'(s_ready), 64'(2'b11));
    endtask

    // Accept on edge E, then expect each engine to present exactly one result pulse.
    task automatic run_job(input string tag, input logic [63:0] data, input logic [LW-1:0] len,
                           input logic [31:0] eh, input logic [LW-1:0] el,
                           input int lat1, input int lat4);
        int          lat [2];
        int          cnt [2];
        logic [31:0] h   [2];
        logic [LW-1:0] l [2];
        bit          seen [2];
        int          exp_lat [2];
        exp_lat[0] = lat1;
        exp_lat[1] = lat4;
        for (int i = 0; i < 2; i++) begin
            seen[i] = 1'b0; cnt[i] = 0; lat[i] = 0; h[i] = '0; l[i] = '0;
        end
        wait_ready(tag);
        m_ready = 1'b1;
        s_data  = data;
        s_len   = len;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = ~data;
        s_len   = 4'd3;
        check($sformatf("%s/busy", tag), 64'(s_ready), 64'(2'b00));
        for (int k = 1; k <= 20 && !(seen[0] && seen[1]); k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                cnt[i] += int'(m_valid[i]);
                if (m_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1; lat[i] = k; h[i] = m_hash[i]; l[i] = m_len[i];
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) cnt[i] += int'(m_valid[i]);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s/L%0d seen", tag, i * 3 + 1), 64'(seen[i]), 64'(1));
            check($sformatf("%s/L%0d lat", tag, i * 3 + 1), 64'(lat[i]), 64'(exp_lat[i]));
            check($sformatf("%s/L%0d hash", tag, i * 3 + 1), 64'(h[i]), 64'(eh));
            check($sformatf("%s/L%0d len", tag, i * 3 + 1), 64'(l[i]), 64'(el));
            check($sformatf("%s/L%0d pulse", tag, i * 3 + 1), 64'(cnt[i]), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int guard;
        int any_valid;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0; s_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/s_ready", 64'(s_ready), 64'(0));
        check("rst/m_valid", 64'(m_valid), 64'(0));
        check("rst/m_hash1", 64'(m_hash[0]), 64'(0));
        check("rst/m_len4", 64'(m_len[1]), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst/first_ready", 64'(s_ready), 64'(2'b11));

        // Bytes beyond len carry junk that must not enter the hash.
        run_job("a", 64'h61FF_EEDD_CCBB_AA99, 4'd1, 32'h0000_0061, 4'd1, 1, 1);
        run_job("ab", 64'h6162_FFEE_DDCC_BBAA, 4'd2, 32'h0061_1841, 4'd2, 2, 1);
        run_job("len0", 64'h7172_7374_7576_7778, 4'd0, 32'h0, 4'd0, 1, 1);
        run_job("hello", 64'h6865_6C6C_6F11_2233, 4'd5,
                sdbm_ref(64'h6865_6C6C_6F11_2233, 5), 4'd5, 5, 2);
        run_job("clamp", 64'h6162_6364_6566_6768, 4'(MB + 5),
                sdbm_ref(64'h6162_6364_6566_6768, 8), 4'd8, 8, 2);
`ifdef SDBM_NUL_STOP_EN
        run_job("nul", 64'h6100_6244_5566_7788, 4'd3, 32'h0000_0061, 4'd1, 2, 1);
`else
        run_job("nul", 64'h6100_6244_5566_7788, 4'd3, 32'h2FC3_E043, 4'd3, 3, 1);
`endif

        // Backpressure: results must hold while m_ready stays low.
        wait_ready("hold");
        m_ready = 1'b0;
        s_data  = 64'h6162_0000_0000_0000;
        s_len   = 4'd2;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        guard = 0;
        while (m_valid != 2'b11 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("hold/valid", 64'(m_valid), 64'(2'b11));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold/valid%0d", k), 64'(m_valid), 64'(2'b11));
            check($sformatf("hold/ready%0d", k), 64'(s_ready), 64'(2'b00));
            check($sformatf("hold/hash1_%0d", k), 64'(m_hash[0]), 64'(32'h0061_1841));
            check($sformatf("hold/hash4_%0d", k), 64'(m_hash[1]), 64'(32'h0061_1841));
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("hold/release_valid", 64'(m_valid), 64'(2'b00));
        check("hold/release_ready", 64'(s_ready), 64'(2'b11));

        // Reset mid-job on the 1-lane engine: no partial result may follow.
        s_data  = 64'h6162_6364_6566_6768;
        s_len   = 4'd8;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort/s_ready", 64'(s_ready), 64'(0));
        check("abort/m_valid", 64'(m_valid), 64'(0));
        check("abort/m_hash1", 64'(m_hash[0]), 64'(0));
        check("abort/m_len1", 64'(m_len[0]), 64'(0));
        rst = 1'b0;
        any_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (m_valid != 2'b00) any_valid++;
        end
        check("abort/no_result", 64'(any_valid), 64'(0));
        run_job("ab_after_rst", 64'h6162_0102_0304_0506, 4'd2, 32'h0061_1841, 4'd2, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
